// File: rtl/systolic_mm_if.sv
// Host/array-facing bundle for systolic_mm_controller.
// Host side: start, load_en/load_sel/load_row/load_col/load_data in; busy, done, result out.
// Array side: arr_reset, arr_in_a, arr_in_b out; arr_out_sum in (row-major, i*N+j).
// master = host + array instance, slave = controller.
interface systolic_mm_if #(
    parameter int DATA_SIZE   = 32,
    parameter int MATRIX_SIZE = 3
);
    localparam int N  = MATRIX_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                          start;
    logic                          load_en;
    logic                          load_sel;
    logic [IW-1:0]                 load_row;
    logic [IW-1:0]                 load_col;
    logic [DATA_SIZE-1:0]          load_data;
    logic                          busy;
    logic                          done;
    logic                          arr_reset;
    logic [N-1:0][DATA_SIZE-1:0]   arr_in_a;
    logic [N-1:0][DATA_SIZE-1:0]   arr_in_b;
    logic [N*N-1:0][DATA_SIZE-1:0] arr_out_sum;
    logic [N*N-1:0][DATA_SIZE-1:0] result;

    modport master (
        output start, load_en, load_sel, load_row, load_col, load_data, arr_out_sum,
        input  busy, done, arr_reset, arr_in_a, arr_in_b, result
    );
    modport slave (
        input  start, load_en, load_sel, load_row, load_col, load_data, arr_out_sum,
        output busy, done, arr_reset, arr_in_a, arr_in_b, result
    );
endinterface

// File: rtl/systolic_mm_controller.sv
// Sequencer for an NxN systolic matrix-multiply array.
// Buffers A and B from the load port, and on start runs CLEAR -> FEED (2N-1) ->
// DRAIN (N) -> CAPTURE, driving skewed operand streams and latching the product.
// Ports: clk, reset (async, active high), bus (systolic_mm_if.slave).
// All bus outputs are registered from next-state values (Moore, valid whole cycle).
module systolic_mm_controller #(
    parameter int DATA_SIZE   = 32,
    parameter int MATRIX_SIZE = 3
) (
    input  logic           clk,
    input  logic           reset,
    systolic_mm_if.slave   bus
);
    localparam int N  = MATRIX_SIZE;
    localparam int DW = DATA_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(3 * N - 2);
    localparam logic [CW-1:0] N_CNT      = CW'(N);
    localparam logic [IW:0]   N_IDX      = (IW + 1)'(N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N-1:0][N-1:0][DW-1:0] a_q, b_q;        // [row][col]
    logic [N-1:0][DW-1:0]       in_a_q, in_b_q, in_a_d, in_b_d;
    logic [N*N-1:0][DW-1:0]     res_q;
    logic                       busy_q, done_q, arr_rst_q;
    logic                       wr_ok;

    assign wr_ok = (state_q == IDLE) && bus.load_en &&
                   ({1'b0, bus.load_row} < N_IDX) && ({1'b0, bus.load_col} < N_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == FEED_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DRAIN_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i carries A[i][t-i] and B[t-i][i]. When t < i the subtraction wraps
    // to a value far above N, so the single k < N test covers both bounds.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [CW-1:0] OFF = CW'(i);
        logic [CW-1:0] k;
        logic          live;
        assign k         = cnt_d - OFF;
        assign live      = (state_d == FEED) && (k < N_CNT);
        assign in_a_d[i] = live ? a_q[i][IW'(k)] : '0;
        assign in_b_d[i] = live ? b_q[IW'(k)][i] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            in_a_q    <= '0;
            in_b_q    <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arr_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_a_q    <= in_a_d;
            in_b_q    <= in_b_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == CAPTURE);
            arr_rst_q <= (state_d == CLEAR);
            // Latch on entry to CAPTURE so result is valid alongside done.
            if (state_q == DRAIN && state_d == CAPTURE) res_q <= bus.arr_out_sum;
            if (wr_ok) begin
                if (bus.load_sel) b_q[bus.load_row][bus.load_col] <= bus.load_data;
                else              a_q[bus.load_row][bus.load_col] <= bus.load_data;
            end
        end
    end

    // Array clear is also forced for as long as reset is held.
    assign bus.arr_reset = arr_rst_q | reset;
    assign bus.arr_in_a  = in_a_q;
    assign bus.arr_in_b  = in_b_q;
    assign bus.result    = res_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_mm_controller.sv
// Bench for systolic_mm_controller: a 32-bit and an 8-bit instance, each wired
// to a behavioural systolic array (a passes right, b passes down, PE accumulates).
module tb_systolic_mm_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_mm_if #(.DATA_SIZE(32), .MATRIX_SIZE(3)) bus ();
    systolic_mm_if #(.DATA_SIZE(8),  .MATRIX_SIZE(3)) bus8 ();

    systolic_mm_controller #(.DATA_SIZE(32), .MATRIX_SIZE(3)) dut  (.clk(clk), .reset(reset), .bus(bus));
    systolic_mm_controller #(.DATA_SIZE(8),  .MATRIX_SIZE(3)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    for (genvar i = 0; i < 3; i++) begin : g_r
        for (genvar j = 0; j < 3; j++) begin : g_c
            logic [31:0] ain, bin, pa, pb, s;
            logic [7:0]  ain8, bin8, pa8, pb8, s8;
            if (j == 0) begin : g_a0
                assign ain  = bus.arr_in_a[i];
                assign ain8 = bus8.arr_in_a[i];
            end else begin : g_an
                assign ain  = g_r[i].g_c[j-1].pa;
                assign ain8 = g_r[i].g_c[j-1].pa8;
            end
            if (i == 0) begin : g_b0
                assign bin  = bus.arr_in_b[j];
                assign bin8 = bus8.arr_in_b[j];
            end else begin : g_bn
                assign bin  = g_r[i-1].g_c[j].pb;
                assign bin8 = g_r[i-1].g_c[j].pb8;
            end
            always @(posedge clk) begin
                if (bus.arr_reset) begin
                    pa <= '0; pb <= '0; s <= '0;
                end else begin
                    pa <= ain; pb <= bin; s <= s + ain * bin;
                end
                if (bus8.arr_reset) begin
                    pa8 <= '0; pb8 <= '0; s8 <= '0;
                end else begin
                    pa8 <= ain8; pb8 <= bin8; s8 <= s8 + ain8 * bin8;
                end
            end
            assign bus.arr_out_sum[i*3+j]  = s;
            assign bus8.arr_out_sum[i*3+j] = s8;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input bit sel, input int unsigned m[9]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                bus.load_sel  = sel;
                bus.load_row  = 2'(r);
                bus.load_col  = 2'(c);
                bus.load_data = m[r*3+c];
                bus.load_en   = 1'b1;
                tick;
            end
        bus.load_en = 1'b0;
    endtask

    // mode 1: check skewed streams; mode 2: inject start + load during FEED
    task automatic run(input string tag, input int unsigned e[9], input int mode);
        int cyc, nrst;
        bit got;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1; nrst = 0; got = 1'b0;
        while (cyc < 40) begin
            if (bus.arr_reset) nrst++;
            if (bus.done) begin got = 1'b1; break; end
            if (mode == 1 && cyc == 2) begin
                chk("t0_a0", bus.arr_in_a[0], 1); chk("t0_a1", bus.arr_in_a[1], 0);
                chk("t0_a2", bus.arr_in_a[2], 0); chk("t0_b0", bus.arr_in_b[0], 2);
                chk("t0_b1", bus.arr_in_b[1], 0); chk("t0_b2", bus.arr_in_b[2], 0);
            end
            if (mode == 1 && cyc == 4) begin
                chk("t2_a0", bus.arr_in_a[0], 3); chk("t2_a1", bus.arr_in_a[1], 5);
                chk("t2_a2", bus.arr_in_a[2], 7); chk("t2_b0", bus.arr_in_b[0], 6);
                chk("t2_b1", bus.arr_in_b[1], 5); chk("t2_b2", bus.arr_in_b[2], 3);
            end
            if (mode == 1 && cyc == 6) begin
                chk("t4_a0", bus.arr_in_a[0], 0); chk("t4_a1", bus.arr_in_a[1], 0);
                chk("t4_a2", bus.arr_in_a[2], 9); chk("t4_b0", bus.arr_in_b[0], 0);
                chk("t4_b1", bus.arr_in_b[1], 0); chk("t4_b2", bus.arr_in_b[2], 8);
            end
            if (mode == 2 && cyc == 3) begin
                bus.start = 1'b1; bus.load_en = 1'b1; bus.load_sel = 1'b0;
                bus.load_row = 2'd0; bus.load_col = 2'd0; bus.load_data = 32'd10;
                tick; cyc++;
                bus.start = 1'b0; bus.load_en = 1'b0;
                continue;
            end
            tick;
            cyc++;
        end
        chk({tag, "_done"}, 32'(got), 1);
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_busy_cap"}, 32'(bus.busy), 1);
        chk({tag, "_arr_reset_pulses"}, nrst, 1);
        for (int k = 0; k < 9; k++) chk($sformatf("%s_res%0d", tag, k), bus.result[k], e[k]);
        tick;
        chk({tag, "_done_fall"}, 32'(bus.done), 0);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 0);
    endtask

    task automatic run8(input string tag, input logic [7:0] v, input logic [7:0] ex);
        int cyc;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 9; k++) begin
                bus8.load_sel = s[0]; bus8.load_row = 2'(k / 3); bus8.load_col = 2'(k % 3);
                bus8.load_data = v; bus8.load_en = 1'b1;
                tick;
            end
        bus8.load_en = 1'b0;
        bus8.start = 1'b1;
        tick;
        bus8.start = 1'b0;
        cyc = 1;
        while (!bus8.done && cyc < 40) begin tick; cyc++; end
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_done"}, 32'(bus8.done), 1);
        for (int k = 0; k < 9; k += 4) chk($sformatf("%s_res%0d", tag, k), 32'(bus8.result[k]), 32'(ex));
        tick;
    endtask

    int unsigned ma[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int unsigned mb[9]  = '{2, 1, 3, 4, 5, 7, 6, 9, 8};
    int unsigned mp[9]  = '{28, 38, 41, 64, 83, 95, 100, 128, 149};
    int unsigned mi[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int unsigned mz[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int nd;
        bus.start = 0; bus.load_en = 0; bus.load_sel = 0;
        bus.load_row = 0; bus.load_col = 0; bus.load_data = 0;
        bus8.start = 0; bus8.load_en = 0; bus8.load_sel = 0;
        bus8.load_row = 0; bus8.load_col = 0; bus8.load_data = 0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_arr_reset", 32'(bus.arr_reset), 1);
        chk("rst_in_a0", bus.arr_in_a[0], 0);
        chk("rst_res4", bus.result[4], 0);
        tick; tick;
        reset = 1'b0;
        tick;
        chk("post_rst_arr_reset", 32'(bus.arr_reset), 0);
        chk("post_rst_busy", 32'(bus.busy), 0);

        ld(1'b0, ma);
        ld(1'b1, mb);
        run("run1", mp, 1);
        run("rerun", mp, 0);

        run("ignore", mp, 2);
        nd = 0;
        repeat (12) begin if (bus.done || bus.busy) nd++; tick; end
        chk("ignore_no_extra", nd, 0);
        run("after_ignore", mp, 0);

        // reset during DRAIN
        bus.start = 1'b1; tick; bus.start = 1'b0;
        repeat (7) tick;
        chk("drain_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_res0", bus.result[0], 0);
        chk("mid_rst_res8", bus.result[8], 0);
        chk("mid_rst_in_a2", bus.arr_in_a[2], 0);
        chk("mid_rst_in_b2", bus.arr_in_b[2], 0);
        chk("mid_rst_arr_reset", 32'(bus.arr_reset), 1);
        tick;
        reset = 1'b0;
        nd = 0;
        repeat (15) begin if (bus.done) nd++; tick; end
        chk("mid_rst_no_done", nd, 0);
        ld(1'b0, ma);
        ld(1'b1, mb);
        run("fresh", mp, 0);

        // out-of-range row write must not disturb A
        bus.load_sel = 1'b0; bus.load_row = 2'd3; bus.load_col = 2'd0;
        bus.load_data = 32'd99; bus.load_en = 1'b1; tick; bus.load_en = 1'b0;
        ld(1'b0, mi);
        run("identity", mb, 0);
        ld(1'b0, mz);
        ld(1'b1, mz);
        run("zero", mz, 0);

        run8("w8_16", 8'd16, 8'd0);
        run8("w8_10", 8'd10, 8'd44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_mm_controller.md
# systolic_mm_controller

Sequencer for the `MATRIX_SIZE`×`MATRIX_SIZE` systolic matrix_multiply array. It buffers operand matrices A and B written over a simple load port. On `start` it clears the array, then drives the diagonally skewed `in_a`/`in_b` streams for the required number of cycles. It waits for the array to drain, latches the product matrix, and signals `done`. It sits between the host/load logic and the array instance; the array's `reset`, `in_a`, `in_b` and `out_matrix` connect directly to this block.

## Interface
- `DATA_SIZE`, 32: width of every operand, array port and result element.
- `MATRIX_SIZE`, 3: N, the matrix dimension; N ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to multiply the buffered A×B.
- `load_en` in 1: write strobe for operand buffers.
- `load_sel` in 1: 0 writes A, 1 writes B.
- `load_row`, `load_col` in $clog2(N): element index [row][col].
- `load_data` in DATA_SIZE: element value.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: one-cycle pulse when `result` is updated.
- `arr_reset` out 1: clear to the array accumulators.
- `arr_in_a` out DATA_SIZE [N]: row-skewed A stream to the array.
- `arr_in_b` out DATA_SIZE [N]: column-skewed B stream to the array.
- `arr_out_sum` in DATA_SIZE [N*N]: array accumulators, row-major (index i*N+j).
- `result` out DATA_SIZE [N*N]: latched product, row-major.

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → CAPTURE → IDLE. All outputs are registered (Moore) and valid for the whole state cycle.
- IDLE
  - `start`=1 → CLEAR.
  - `load_en` writes `load_data` into A[row][col] or B[row][col]. Index ≥ N is ignored.
- CLEAR: one cycle. `arr_reset`=1, streams zero.
- FEED: 2N−1 cycles with step counter t=0..2N−2.
  - `arr_in_a[i]` = A[i][t−i] if 0 ≤ t−i < N, else 0.
  - `arr_in_b[j]` = B[t−j][j] if 0 ≤ t−j < N, else 0.
- DRAIN: N cycles. Streams driven 0; counter continues t=2N−1..3N−2.
- CAPTURE: one cycle. `result` ← `arr_out_sum`, `done`=1, `busy` remains 1 in this cycle. Next state is IDLE.
- `start` while not IDLE is ignored. No queuing.
- `load_en` while not IDLE is ignored, so buffers are frozen during a run. A write in the same IDLE cycle as `start` is applied and is used by that run.
- Arithmetic is done by the array. This block never modifies data. Results wrap modulo 2^DATA_SIZE by array width.
- `result` holds its last value until the next CAPTURE. A/B buffers persist across runs, so re-`start` without loads recomputes the same product.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `arr_reset`=1 while reset asserted and 0 after, streams 0, `result` all 0, A/B buffers all 0, counter 0.
- Reset mid-run: immediate return to IDLE with the above values. `result` is cleared and no `done` is produced.
- Cycle numbering: `start` sampled at edge k.
  - CLEAR occupies cycle k+1.
  - FEED occupies k+2..k+2N.
  - DRAIN occupies k+2N+1..k+3N.
  - CAPTURE occupies k+3N+1.
- Latency from `start` to `done` is 3N+1 cycles (10 for N=3). `busy` is high for 3N+1 cycles.
- A new `start` is accepted the cycle after CAPTURE, so back-to-back throughput is one run per 3N+2 cycles.
- Capture at step 3N−1 is sufficient: the last product (A[N−1][N−1]·B[N−1][N−1]) reaches PE(N−1,N−1) at step 3N−3 and accumulates at that edge.

## Test plan
- N=3, load A=[1 2 3;4 5 6;7 8 9], B=[2 1 3;4 5 7;6 9 8], pulse `start`.
  - FEED cycle t=0: `arr_in_a`={1,0,0}, `arr_in_b`={2,0,0}.
  - t=2: {3,5,7} / {6,5,3}.
  - t=4: {0,0,9} / {0,0,8}.
  - `done` exactly 10 cycles after `start`; `result`=[28 38 41;64 83 95;100 128 149].
- Second `start` without reloading → same `result`, `done` again 10 cycles later. `arr_reset` pulses once in CLEAR.
- `start` and `load_en` (A[0][0]=10) pulsed mid-FEED → both ignored. Result unchanged, no extra `done`. A later run still uses A[0][0]=1.
- Assert `reset` during DRAIN → same cycle `busy`=0, `result`=0, streams 0. No `done` pulse follows. A fresh load+start then gives the correct product.
- Identity A=I, B=[2 1 3;4 5 7;6 9 8] → `result`=B. With all-zero A, B → `result` all 0 and `done` still asserted.
- DATA_SIZE=8 with A=B=all 16 → each element 768 mod 256 = 0. Confirms wrap behaviour is passed through unchanged.
